parking_lot_multi: RTL and testbench
====================================

Name: parking_lot_multi

Overview:
Multi-lane parking-lot occupancy tracker, the parametrised successor to the single-lane A/B-sensor detector plus counter.
- Each of LANES lanes has one A/B sensor pair.
- Each lane is synchronised and decoded by its own direction FSM into single-cycle enter/exit pulses.
- All lane pulses are summed into one saturating occupancy counter, with full, empty and sticky error flags.
- Sits between the board-level sensor inputs and the hex display driver.

Parameters:
LANES, 2, number of independent sensor lanes (1..8)
CAPACITY, 25, maximum occupancy; counter clamps here
SYNC_STAGES, 2, flip-flop synchroniser depth per sensor bit (>=2)
CNT_W, $clog2(CAPACITY+1), occupancy count width (derived, not overridden)
STAT_W, 16, width of optional lifetime totals

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear of count and sat_err; FSMs unaffected
sensor_a  in  LANES  raw outer-sensor level per lane, 1 = blocked, asynchronous
sensor_b  in  LANES  raw inner-sensor level per lane, 1 = blocked, asynchronous
enter  out  LANES  one-cycle pulse per completed entry sequence
exit  out  LANES  one-cycle pulse per completed exit sequence
count  out  CNT_W  current occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0
sat_err  out  1  sticky; set when an event was discarded by clamping
total_in  out  STAT_W  only with PARKING_STATS_EN
total_out  out  STAT_W  only with PARKING_STATS_EN

Behaviour:
- Reset (async, on reset high):
  - synchronisers 0, all FSMs IDLE
  - enter/exit 0, count 0, sat_err 0
  - empty 1, full 0 (full is 1 only if CAPACITY == 0, which is illegal)
- Per-lane synchroniser:
  - SYNC_STAGES flops per bit; the FSM sees {a,b} = last stage.
- Per-lane FSM, registered. Input ab = {a,b}.
  - IDLE: 10->EN1; 01->EX1; 11->WAIT; 00->IDLE
  - EN1: 11->EN2; 00->IDLE; 01->WAIT; 10 hold
  - EN2: 01->EN3; 10->EN1; 00->WAIT; 11 hold
  - EN3: 00->IDLE and assert enter; 11->EN2; 10->WAIT; 01 hold
  - EX1: 11->EX2; 00->IDLE; 10->WAIT; 01 hold
  - EX2: 10->EX3; 01->EX1; 00->WAIT; 11 hold
  - EX3: 00->IDLE and assert exit; 11->EX2; 01->WAIT; 10 hold
  - WAIT: stay until ab==00, then IDLE, no pulse.
- Pulse timing:
  - enter/exit are registered and high exactly one cycle, the cycle after the FSM leaves EN3/EX3.
  - Latency from raw sensor reaching 00 to pulse: SYNC_STAGES+1 clk edges.
  - A pedestrian who reverses partway (e.g. 10,11,10,00) produces no pulse.
- Counter:
  - Each cycle, n_in = popcount(enter) and n_out = popcount(exit).
  - next = count + n_in - n_out, computed signed at width CNT_W+4, then clamped to [0, CAPACITY].
  - If clamping changed the result, sat_err <= 1.
  - count updates one cycle after the pulses.
  - Simultaneous enter and exit across lanes net out before clamping, e.g. count 25 with one enter and one exit stays 25 with no sat_err.
- full and empty are combinational from count.
- clr:
  - count <= 0 and sat_err <= 0; pulses that cycle are discarded.
  - clr has priority over increments.
- Reset mid-sequence returns the lane to IDLE; the completed tail of that sequence yields no pulse.

Optional Feature:
PARKING_STATS_EN
- Defined:
  - total_in and total_out are free-running STAT_W counters that wrap modulo 2^STAT_W.
  - They add n_in and n_out every cycle, unclamped.
  - reset zeroes them; clr does not.
- Undefined: the ports and logic are absent.

Decomposition:
- Package parking_pkg:
  - lane_state_t enum {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT}
  - AB_NONE/AB_A/AB_B/AB_BOTH 2-bit constants.
- Sub-module parking_lane_fsm, one per lane via generate: clk, reset, raw a/b in, enter/exit out, synchroniser included.
- Popcount, counter and flags live in the top.

Test Plan:
- Lane0 raw 00,10,11,01,00 (each held 4 clk) -> enter[0] one-cycle pulse SYNC_STAGES+1 edges after final 00; count 0->1; empty falls.
- Lane1 01,11,10,00 with count 1 -> exit[1] pulse; count 0; empty 1; sat_err 0.
- Abort 10,11,10,00 and illegal jump 00->11->01->00 -> no pulses; FSM passes through WAIT; count unchanged.
- CAPACITY=3, four entries -> count saturates at 3, full 1, sat_err 1; a later clr -> count 0, sat_err 0.
- Count 25 (default), lane0 enter and lane1 exit in the same cycle -> count stays 25, sat_err 0; count 0 with a single exit -> stays 0, sat_err 1.
- reset asserted mid-EN2 then released, sensors finish 01,00 -> no enter pulse, count 0; with PARKING_STATS_EN, after 3 entries and 1 exit -> total_in 3, total_out 1.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the multi-lane parking occupancy tracker.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT
  } lane_state_t;

  // Sensor pair encodings, {a,b}
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/parking_lane_fsm.sv
// One sensor lane: synchroniser plus direction FSM emitting
// single-cycle enter/exit pulses.
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic exit
);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             ab;
  lane_state_t            state;

  assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      state  <= IDLE;
      enter  <= 1'b0;
      exit   <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b};
      enter  <= 1'b0;
      exit   <= 1'b0;
      unique case (state)
        IDLE:
          case (ab)
            AB_A:    state <= EN1;
            AB_B:    state <= EX1;
            AB_BOTH: state <= WAIT;
            default: ;
          endcase
        EN1:
          case (ab)
            AB_BOTH: state <= EN2;
            AB_NONE: state <= IDLE;
            AB_B:    state <= WAIT;
            default: ;
          endcase
        EN2:
          case (ab)
            AB_B:    state <= EN3;
            AB_A:    state <= EN1;
            AB_NONE: state <= WAIT;
            default: ;
          endcase
        EN3:
          case (ab)
            AB_NONE: begin
              state <= IDLE;
              enter <= 1'b1;
            end
            AB_BOTH: state <= EN2;
            AB_A:    state <= WAIT;
            default: ;
          endcase
        EX1:
          case (ab)
            AB_BOTH: state <= EX2;
            AB_NONE: state <= IDLE;
            AB_A:    state <= WAIT;
            default: ;
          endcase
        EX2:
          case (ab)
            AB_A:    state <= EX3;
            AB_B:    state <= EX1;
            AB_NONE: state <= WAIT;
            default: ;
          endcase
        EX3:
          case (ab)
            AB_NONE: begin
              state <= IDLE;
              exit  <= 1'b1;
            end
            AB_BOTH: state <= EX2;
            AB_B:    state <= WAIT;
            default: ;
          endcase
        WAIT:
          if (ab == AB_NONE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_multi.sv
// Multi-lane occupancy tracker with saturating counter.
// Define PARKING_STATS_EN to add lifetime total_in/total_out.
module parking_lot_multi
  import parking_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int CAPACITY    = 25,
  parameter int SYNC_STAGES = 2,
  parameter int STAT_W      = 16,
  localparam int CNT_W      = $clog2(CAPACITY+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [LANES-1:0] sensor_a,
  input  logic [LANES-1:0] sensor_b,
  output logic [LANES-1:0] enter,
  output logic [LANES-1:0] exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             sat_err
`ifdef PARKING_STATS_EN
  ,
  output logic [STAT_W-1:0] total_in,
  output logic [STAT_W-1:0] total_out
`endif
);

  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    parking_lane_fsm #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .a    (sensor_a[i]),
      .b    (sensor_b[i]),
      .enter(enter[i]),
      .exit (exit[i])
    );
  end

  logic [3:0]             n_in;
  logic [3:0]             n_out;
  logic signed [SW-1:0]   sum;
  logic [CNT_W-1:0]       next_cnt;
  logic                   clamp;

  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < LANES; i++) begin
      n_in  = n_in + 4'(enter[i]);
      n_out = n_out + 4'(exit[i]);
    end
  end

  // Net all lanes first, then clamp once
  always_comb begin
    sum = $signed(SW'(count)) + $signed(SW'(n_in))
        - $signed(SW'(n_out));
    next_cnt = sum[CNT_W-1:0];
    clamp    = 1'b0;
    if (sum[SW-1]) begin
      next_cnt = '0;
      clamp    = 1'b1;
    end else if (sum > CAP_S) begin
      next_cnt = CNT_W'(CAPACITY);
      clamp    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      sat_err <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      sat_err <= 1'b0;
    end else begin
      count <= next_cnt;
      if (clamp) sat_err <= 1'b1;
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

`ifdef PARKING_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_in  <= '0;
      total_out <= '0;
    end else begin
      total_in  <= total_in + STAT_W'(n_in);
      total_out <= total_out + STAT_W'(n_out);
    end
  end
`endif

endmodule

// File: tb/tb_parking_lot_multi.sv
// Bench for parking_lot_multi: directed scenarios plus random
// lane scripts against a chain-position reference model.
module tb_parking_lot_multi;

  localparam int L   = 2;
  localparam int CAP = 25;
  localparam int S   = 2;
  localparam int SW  = 16;
  localparam int CW  = $clog2(CAP+1);

  localparam logic [7:0] ENTRY = 8'b10_11_01_00;
  localparam logic [7:0] EXITS = 8'b01_11_10_00;
  localparam logic [7:0] ABORT = 8'b10_11_10_00;
  localparam logic [7:0] JUMP  = 8'b11_01_00_00;
  localparam logic [7:0] NONE  = 8'b00_00_00_00;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic [L-1:0]  sensor_a, sensor_b, enter, exit;
  logic [CW-1:0] count;
  logic          full, empty, sat_err;
`ifdef PARKING_STATS_EN
  logic [SW-1:0] total_in, total_out;
`endif

  always #5 clk = ~clk;

  parking_lot_multi #(
    .LANES(L), .CAPACITY(CAP),
    .SYNC_STAGES(S), .STAT_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .sensor_a(sensor_a), .sensor_b(sensor_b),
    .enter(enter), .exit(exit), .count(count),
    .full(full), .empty(empty), .sat_err(sat_err)
`ifdef PARKING_STATS_EN
    , .total_in(total_in)
    , .total_out(total_out)
`endif
  );

  int checks = 0;
  int passes = 0;

  // Reference model state
  int           mcount, mtot_in, mtot_out;
  bit           msat;
  logic [L-1:0] pipe_en[$], pipe_ex[$];
  logic [L-1:0] prev_en, prev_ex, exp_en, exp_ex;
  logic [1:0]   last_ab[L];
  int           pos[L];
  bit           dir_in[L];
  bit           bad[L];
  int           pulse_mism = 0;
  int           obs_en_cnt, obs_ex_cnt;
  logic [L-1:0] cur_a, cur_b;
  logic         cur_clr;

  // Position of a nonzero {a,b} along an entry or exit walk
  function automatic int chain_idx(bit din, logic [1:0] v);
    if (v == 2'b11) return 2;
    if (din) return (v == 2'b10) ? 1 : 3;
    return (v == 2'b01) ? 1 : 3;
  endfunction

  function automatic void lane_step(input int l, input logic [1:0] v,
                                    output logic pe, output logic px);
    int p;
    pe = 1'b0;
    px = 1'b0;
    if (v == 2'b00) begin
      if (!bad[l] && pos[l] == 3) begin
        pe = dir_in[l];
        px = !dir_in[l];
      end
      pos[l] = 0;
      bad[l] = 0;
    end else if (!bad[l]) begin
      if (pos[l] == 0) begin
        if (v == 2'b11) bad[l] = 1;
        else begin
          dir_in[l] = (v == 2'b10);
          pos[l] = 1;
        end
      end else begin
        p = chain_idx(dir_in[l], v);
        if (p == pos[l] + 1 || p == pos[l] - 1) pos[l] = p;
        else bad[l] = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    pipe_en.delete();
    pipe_ex.delete();
    for (int i = 0; i < S; i++) begin
      pipe_en.push_back('0);
      pipe_ex.push_back('0);
    end
    prev_en = '0; prev_ex = '0;
    mcount = 0; msat = 0;
    mtot_in = 0; mtot_out = 0;
    obs_en_cnt = 0; obs_ex_cnt = 0;
    for (int l = 0; l < L; l++) begin
      last_ab[l] = 2'b00; pos[l] = 0;
      dir_in[l] = 0; bad[l] = 0;
    end
  endfunction

  // One clock: starts and ends on a falling edge
  task automatic tick();
    logic [L-1:0] ev_en, ev_ex;
    logic [1:0]   v;
    logic         pe, px;
    int           nxt;
    sensor_a = cur_a; sensor_b = cur_b; clr = cur_clr;
    ev_en = '0; ev_ex = '0;
    for (int l = 0; l < L; l++) begin
      v = {cur_a[l], cur_b[l]};
      if (v != last_ab[l]) begin
        lane_step(l, v, pe, px);
        ev_en[l] = pe; ev_ex[l] = px;
        last_ab[l] = v;
      end
    end
    mtot_in  += $countones(prev_en);
    mtot_out += $countones(prev_ex);
    if (cur_clr) begin
      mcount = 0; msat = 0;
    end else begin
      nxt = mcount + $countones(prev_en) - $countones(prev_ex);
      if (nxt < 0) begin nxt = 0; msat = 1; end
      else if (nxt > CAP) begin nxt = CAP; msat = 1; end
      mcount = nxt;
    end
    pipe_en.push_back(ev_en);
    pipe_ex.push_back(ev_ex);
    exp_en = pipe_en.pop_front();
    exp_ex = pipe_ex.pop_front();
    @(negedge clk);
    if (enter !== exp_en || exit !== exp_ex) pulse_mism++;
    obs_en_cnt += $countones(enter);
    obs_ex_cnt += $countones(exit);
    prev_en = exp_en; prev_ex = exp_ex;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ab(input int l, input logic [1:0] v);
    cur_a[l] = v[1];
    cur_b[l] = v[0];
  endtask

  // Four steps per lane, each held 4 clocks, then settle
  task automatic seq4(input logic [7:0] s0, input logic [7:0] s1);
    logic [7:0] t0, t1;
    t0 = s0; t1 = s1;
    for (int j = 0; j < 4; j++) begin
      set_ab(0, t0[7-2*j -: 2]);
      set_ab(1, t1[7-2*j -: 2]);
      hold(4);
    end
    hold(S + 3);
  endtask

  task automatic do_reset(input bit keep_inputs);
    @(negedge clk);
    reset = 1'b1;
    if (!keep_inputs) begin cur_a = '0; cur_b = '0; end
    cur_clr = 1'b0;
    sensor_a = cur_a; sensor_b = cur_b; clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr = 1'b0;
    cur_a = '0; cur_b = '0; cur_clr = 1'b0;
    sensor_a = '0; sensor_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count);
    else passes++;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", empty, full);
    else passes++;
    checks++;
    if (sat_err !== 1'b0 || enter !== '0 || exit !== '0)
      $display("FAIL reset_pulses got s=%b en=%b ex=%b exp 0", sat_err, enter, exit);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_enter();
    logic exp_p;
    set_ab(0, 2'b00); hold(4);
    set_ab(0, 2'b10); hold(4);
    set_ab(0, 2'b11); hold(4);
    set_ab(0, 2'b01); hold(4);
    set_ab(0, 2'b00);
    for (int k = 1; k <= S + 2; k++) begin
      tick();
      if (k <= S + 1) begin
        exp_p = (k == S + 1);
        checks++;
        if (enter[0] !== exp_p)
          $display("FAIL enter_timing edge=%0d got=%b exp=%b", k, enter[0], exp_p);
        else passes++;
      end
    end
    checks++;
    if (count !== CW'(1) || count !== CW'(mcount))
      $display("FAIL enter_count got=%0d exp=1", count);
    else passes++;
    checks++;
    if (empty !== 1'b0) $display("FAIL enter_empty got=%b exp=0", empty);
    else passes++;
  endtask

  task automatic test_exit();
    seq4(NONE, EXITS);
    checks++;
    if (count !== '0 || empty !== 1'b1 || sat_err !== 1'b0)
      $display("FAIL exit_state got c=%0d e=%b s=%b exp 0/1/0", count, empty, sat_err);
    else passes++;
    checks++;
    if (obs_ex_cnt !== 1 || pulse_mism !== 0)
      $display("FAIL exit_pulse got n=%0d mism=%0d exp 1/0", obs_ex_cnt, pulse_mism);
    else passes++;
  endtask

  task automatic test_abort();
    int en0, ex0;
    seq4(ENTRY, NONE);
    en0 = obs_en_cnt; ex0 = obs_ex_cnt;
    seq4(ABORT, JUMP);
    checks++;
    if (obs_en_cnt !== en0 || obs_ex_cnt !== ex0)
      $display("FAIL abort_pulses got en=%0d ex=%0d exp en=%0d ex=%0d",
               obs_en_cnt, obs_ex_cnt, en0, ex0);
    else passes++;
    checks++;
    if (count !== CW'(1) || pulse_mism !== 0)
      $display("FAIL abort_count got=%0d mism=%0d exp 1/0", count, pulse_mism);
    else passes++;
  endtask

  task automatic test_saturate();
    do_reset(0);
    repeat (12) seq4(ENTRY, ENTRY);
    seq4(ENTRY, NONE);
    checks++;
    if (count !== CW'(CAP) || full !== 1'b1 || sat_err !== 1'b0)
      $display("FAIL sat_fill got c=%0d f=%b s=%b exp %0d/1/0", count, full, sat_err, CAP);
    else passes++;
    seq4(ENTRY, EXITS);
    checks++;
    if (count !== CW'(CAP) || sat_err !== 1'b0)
      $display("FAIL sat_net got c=%0d s=%b exp %0d/0", count, sat_err, CAP);
    else passes++;
    seq4(ENTRY, NONE);
    checks++;
    if (count !== CW'(CAP) || sat_err !== 1'b1 || msat !== 1'b1)
      $display("FAIL sat_over got c=%0d s=%b exp %0d/1", count, sat_err, CAP);
    else passes++;
    cur_clr = 1'b1; tick();
    cur_clr = 1'b0; tick();
    checks++;
    if (count !== '0 || sat_err !== 1'b0 || empty !== 1'b1)
      $display("FAIL sat_clr got c=%0d s=%b e=%b exp 0/0/1", count, sat_err, empty);
    else passes++;
    seq4(NONE, EXITS);
    checks++;
    if (count !== '0 || sat_err !== 1'b1)
      $display("FAIL sat_under got c=%0d s=%b exp 0/1", count, sat_err);
    else passes++;
    checks++;
    if (pulse_mism !== 0) $display("FAIL sat_pulses got mism=%0d exp 0", pulse_mism);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    set_ab(0, 2'b10); hold(4);
    set_ab(0, 2'b11); hold(4);
    do_reset(1);
    hold(4);
    set_ab(0, 2'b01); hold(4);
    set_ab(0, 2'b00); hold(S + 4);
    checks++;
    if (obs_en_cnt !== 0 || count !== '0)
      $display("FAIL reset_mid got en=%0d c=%0d exp 0/0", obs_en_cnt, count);
    else passes++;
  endtask

  task automatic test_stats();
    do_reset(0);
    repeat (3) seq4(ENTRY, NONE);
    seq4(NONE, EXITS);
    checks++;
    if (count !== CW'(2)) $display("FAIL stats_count got=%0d exp=2", count);
    else passes++;
`ifdef PARKING_STATS_EN
    checks++;
    if (total_in !== SW'(3) || total_out !== SW'(1))
      $display("FAIL stats_totals got in=%0d out=%0d exp 3/1", total_in, total_out);
    else passes++;
`endif
  endtask

  task automatic test_random();
    logic [7:0] scr[L];
    int         idx[L];
    int         h;
    logic [7:0] t;
    do_reset(0);
    for (int l = 0; l < L; l++) idx[l] = 4;
    for (int step = 0; step < 150; step++) begin
      for (int l = 0; l < L; l++) begin
        if (idx[l] == 4) begin
          case ($urandom_range(0, 3))
            0: scr[l] = ENTRY;
            1: scr[l] = EXITS;
            2: scr[l] = ABORT;
            default: scr[l] = {6'($urandom), 2'b00};
          endcase
          idx[l] = 0;
        end
        t = scr[l];
        set_ab(l, t[7-2*idx[l] -: 2]);
        idx[l]++;
      end
      cur_clr = ($urandom_range(0, 15) == 0);
      tick();
      cur_clr = 1'b0;
      h = $urandom_range(1, 3);
      hold(h);
      checks++;
      if (count !== CW'(mcount) || sat_err !== msat)
        $display("FAIL rand_count step=%0d got c=%0d s=%b exp c=%0d s=%b",
                 step, count, sat_err, mcount, msat);
      else passes++;
      checks++;
      if (full !== (mcount == CAP) || empty !== (mcount == 0))
        $display("FAIL rand_flags step=%0d got f=%b e=%b mcount=%0d",
                 step, full, empty, mcount);
      else passes++;
    end
    checks++;
    if (pulse_mism !== 0) $display("FAIL rand_pulses got mism=%0d exp 0", pulse_mism);
    else passes++;
`ifdef PARKING_STATS_EN
    checks++;
    if (total_in !== SW'(mtot_in) || total_out !== SW'(mtot_out))
      $display("FAIL rand_totals got in=%0d out=%0d exp in=%0d out=%0d",
               total_in, total_out, mtot_in, mtot_out);
    else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_enter();
    test_exit();
    test_abort();
    test_saturate();
    test_reset_mid();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
